debounce_scheduler: RTL
=======================

Name: debounce_scheduler

Overview:
- Shares a single debounce counter among NUM_BTN push-button inputs instead of giving each button its own counter.
- Each raw button is synchronized. A round-robin FSM picks one button whose level differs from its debounced state and times it for COUNT_MAX stable cycles.
- When the timing completes, the button's debounced state is committed and a one-cycle press or release pulse is emitted.
- Sits between the DE2-115 KEY pins and the control FSMs of the P01 datapath.

Parameters:
- NUM_BTN, 4, number of buttons (2..16).
- CNT_W, 20, debounce counter width.
- COUNT_MAX, 20'd500000, cycles a new level must stay stable before it is committed (1..2^CNT_W-1; 0 is illegal).
- IDX_W, $clog2(NUM_BTN), selector width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-low reset.
- btn_n  input  NUM_BTN  raw buttons, active-low (0 = pressed), asynchronous.
- btn_stable_n  output  NUM_BTN  debounced level per button, active-low.
- press_pulse  output  NUM_BTN  one-cycle pulse on a committed 1->0 transition.
- release_pulse  output  NUM_BTN  one-cycle pulse on a committed 0->1 transition.
- busy  output  1  high while the FSM is in SETTLE or COMMIT.
- sel_idx  output  IDX_W  index of the button being timed; holds its last value in IDLE.

Behaviour:
- Reset (clk edge with rst=0):
  - sync stages and btn_stable_n <= all 1s.
  - press_pulse, release_pulse <= 0; busy <= 0.
  - counter <= 0; rr_ptr <= 0; sel_idx <= 0; state <= IDLE.
  - A reset mid-SETTLE abandons the timing; no pulse is emitted.
- Synchronizer: two flops per bit, giving 2-cycle latency to sync_n.
- mismatch[i] = sync_n[i] ^ btn_stable_n[i].
- IDLE:
  - If any mismatch, choose the first set bit searching circularly from rr_ptr upward.
  - sel_idx <= chosen index, counter <= 0, go to SETTLE.
  - Otherwise stay in IDLE.
- SETTLE:
  - If mismatch[sel_idx] == 0 (bounced back): abort to IDLE, rr_ptr <= sel_idx+1 mod NUM_BTN, no state change, no pulse.
  - Else if counter == COUNT_MAX-1: go to COMMIT.
  - Else counter <= counter+1.
  - Other buttons' mismatches are ignored (they wait their turn).
- COMMIT, one cycle:
  - btn_stable_n[sel_idx] <= sync_n[sel_idx].
  - press_pulse[sel_idx] <= 1 if the new value is 0; else release_pulse[sel_idx] <= 1.
  - rr_ptr <= sel_idx+1 mod NUM_BTN; go to IDLE.
- Pulses are registered, high for exactly the one cycle after the COMMIT edge, and at most one bit is set across both vectors.
- Latency: an input change set up before edge 1 gives a pulse visible after edge COUNT_MAX+4, for one cycle. Breakdown:
  - edges 1-2: synchronizer.
  - edge 3: IDLE->SETTLE.
  - COUNT_MAX SETTLE cycles.
  - COMMIT edge.
- Simultaneous changes on k buttons are serviced sequentially in round-robin order. Each costs COUNT_MAX+2 cycles after the first.
- Fairness: a continuously bouncing button cannot starve others because rr_ptr advances on abort.
- Counter never exceeds COUNT_MAX-1 and does not wrap.
- busy = (state != IDLE), registered.

Decomposition:
- Package Pkg_DebounceSched holds:
  - typedef enum logic [1:0] {IDLE, SETTLE, COMMIT} sched_state_e;
  - the NUM_BTN/CNT_W/COUNT_MAX defaults;
  - BIT_ZERO/BIT_ONE reuse from Pkg_Global.
- One natural sub-module: rr_arbiter, a combinational circular priority finder from rr_ptr that outputs a valid flag and an index.
- Keep the synchronizer inline.

Test Plan (COUNT_MAX=4, NUM_BTN=4 unless stated):
- Reset: hold rst=0 for 3 edges with btn_n=4'b0000 -> btn_stable_n=4'b1111, pulses=0, busy=0. After release with btn_n=1111, no pulses for 50 cycles.
- Clean press: btn_n[2] 1->0 before edge 1, held -> press_pulse=4'b0100 for exactly one cycle after edge 8, and btn_stable_n=4'b1011 from edge 8 onward. A later release gives release_pulse=4'b0100 under the same 8-edge timing.
- Bounce: btn_n[0] low for 3 cycles then high, then low again and held -> first attempt aborts with no pulse. The second attempt commits, with press_pulse[0] 8 edges after the last edge.
- Simultaneous: btn_n 1111->0000 at once -> press pulses in order idx 0,1,2,3, spaced 6 cycles apart (COUNT_MAX+2), busy high throughout.
- Fairness: btn_n[0] toggles every 2 cycles forever while btn_n[3] goes low and is held -> press_pulse[3] occurs within 2*(COUNT_MAX+2)+4 cycles.
- Reset mid-SETTLE: assert rst=0 on the 2nd SETTLE cycle of a btn 1 press -> no pulse, busy=0 next cycle. The press is re-timed from scratch after reset release.

Source files
------------

// File: rtl/debounce_scheduler_pkg.sv
// Shared definitions for the debounce scheduler.
// Holds the scheduler state encoding, the default sizing parameters and the
// single-bit level constants used when decoding active-low button levels.
package debounce_scheduler_pkg;

  localparam int unsigned NUM_BTN_DEF   = 4;
  localparam int unsigned CNT_W_DEF     = 20;
  localparam int unsigned COUNT_MAX_DEF = 500000;

  localparam logic BIT_ZERO = 1'b0;
  localparam logic BIT_ONE  = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COMMIT = 2'd2
  } sched_state_e;

endpackage

// File: rtl/debounce_scheduler_rr_arbiter.sv
// Combinational circular priority finder.
// Returns the first set bit of req searching upward from ptr and wrapping
// around at N-1.
//   req   : request vector, one bit per button
//   ptr   : search start position (always < N)
//   valid : at least one request is set
//   idx   : index of the chosen request (equals ptr when nothing is set)
module debounce_scheduler_rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  int               pos;
  logic [IDX_W-1:0] cand;

  // Walk the offsets from the farthest to the nearest so the candidate
  // closest to ptr is the last one written and therefore wins.
  always_comb begin
    valid = 1'b0;
    idx   = ptr;
    pos   = 0;
    cand  = '0;
    for (int off = int'(N) - 1; off >= 0; off--) begin
      pos  = (int'(ptr) + off) % int'(N);
      cand = IDX_W'(pos);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/debounce_scheduler.sv
// Debounce scheduler: one debounce counter shared by NUM_BTN buttons.
// Raw active-low buttons are double-flop synchronized. A round-robin FSM picks
// one button whose synchronized level differs from its debounced level and
// requires the new level to stay stable for COUNT_MAX cycles before committing
// it and emitting a one-cycle press (1->0) or release (0->1) pulse.
//   clk           : system clock, rising edge
//   rst           : synchronous reset, active low
//   btn_n         : raw buttons, active low, asynchronous
//   btn_stable_n  : debounced levels, active low
//   press_pulse   : one-cycle pulse on a committed 1->0 transition
//   release_pulse : one-cycle pulse on a committed 0->1 transition
//   busy          : scheduler is in SETTLE or COMMIT
//   sel_idx       : button being timed; holds its last value while idle
module debounce_scheduler
  import debounce_scheduler_pkg::*;
#(
  parameter int unsigned NUM_BTN   = NUM_BTN_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF,
  parameter int unsigned COUNT_MAX = COUNT_MAX_DEF,
  parameter int unsigned IDX_W     = $clog2(NUM_BTN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_n,
  output logic [NUM_BTN-1:0] btn_stable_n,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic               busy,
  output logic [IDX_W-1:0]   sel_idx
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT_MAX - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BTN - 1);

  sched_state_e       state, state_nx;
  logic [NUM_BTN-1:0] sync_a, sync_n;
  logic [NUM_BTN-1:0] mismatch;
  logic [NUM_BTN-1:0] stable_nx, press_nx, release_nx;
  logic [CNT_W-1:0]   counter, counter_nx;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_nx, sel_nx, ptr_after_sel;
  logic               arb_valid;
  logic [IDX_W-1:0]   arb_idx;

  assign mismatch      = sync_n ^ btn_stable_n;
  assign ptr_after_sel = (sel_idx == IDX_LAST) ? '0 : sel_idx + IDX_W'(1);

  debounce_scheduler_rr_arbiter #(
    .N     (NUM_BTN),
    .IDX_W (IDX_W)
  ) u_arb (
    .req   (mismatch),
    .ptr   (rr_ptr),
    .valid (arb_valid),
    .idx   (arb_idx)
  );

  always_comb begin
    state_nx   = state;
    counter_nx = counter;
    rr_ptr_nx  = rr_ptr;
    sel_nx     = sel_idx;
    stable_nx  = btn_stable_n;
    press_nx   = '0;
    release_nx = '0;
    case (state)
      IDLE: begin
        if (arb_valid) begin
          sel_nx     = arb_idx;
          counter_nx = '0;
          state_nx   = SETTLE;
        end
      end
      SETTLE: begin
        // A bounce back aborts; advancing rr_ptr keeps a chattering button
        // from monopolising the shared counter.
        if (!mismatch[sel_idx]) begin
          rr_ptr_nx = ptr_after_sel;
          state_nx  = IDLE;
        end else if (counter == CNT_LAST) begin
          state_nx = COMMIT;
        end else begin
          counter_nx = counter + CNT_W'(1);
        end
      end
      COMMIT: begin
        stable_nx[sel_idx] = sync_n[sel_idx];
        // Only pulse on a real level change, so a bounce landing exactly in
        // the commit cycle cannot produce a pulse without a transition.
        if (mismatch[sel_idx]) begin
          if (sync_n[sel_idx] == BIT_ZERO) press_nx[sel_idx] = BIT_ONE;
          else                             release_nx[sel_idx] = BIT_ONE;
        end
        rr_ptr_nx = ptr_after_sel;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_a        <= '1;
      sync_n        <= '1;
      btn_stable_n  <= '1;
      press_pulse   <= '0;
      release_pulse <= '0;
      busy          <= 1'b0;
      counter       <= '0;
      rr_ptr        <= '0;
      sel_idx       <= '0;
      state         <= IDLE;
    end else begin
      sync_a        <= btn_n;
      sync_n        <= sync_a;
      btn_stable_n  <= stable_nx;
      press_pulse   <= press_nx;
      release_pulse <= release_nx;
      busy          <= (state_nx != IDLE);
      counter       <= counter_nx;
      rr_ptr        <= rr_ptr_nx;
      sel_idx       <= sel_nx;
      state         <= state_nx;
    end
  end

endmodule
